// File: rtl/alu_issue_arbiter.sv
// Round-robin issue of NUM_REQ requesters onto one shared integer ALU.
// S1 holds the granted op, S2 holds the registered result driving out_*.
module alu_issue_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int TAG_WIDTH    = 6,
  parameter int OPCODE_WIDTH = 7,
  parameter int FUNCT3_WIDTH = 3,
  parameter int FUNCT7_WIDTH = 7
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_operand1,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_operand2,
  input  logic [NUM_REQ*OPCODE_WIDTH-1:0]    req_opcode,
  input  logic [NUM_REQ*FUNCT3_WIDTH-1:0]    req_funct3,
  input  logic [NUM_REQ*FUNCT7_WIDTH-1:0]    req_funct7,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]       req_tag,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_WIDTH-1:0]              out_result,
  output logic                               out_zero,
  output logic [TAG_WIDTH-1:0]               out_tag,
  output logic [$clog2(NUM_REQ)-1:0]         out_src,
  output logic [1:0]                         inflight
);

  localparam int SRC_W = $clog2(NUM_REQ);
  localparam logic [SRC_W-1:0]        LAST_SRC = SRC_W'(NUM_REQ - 1);
  localparam logic [OPCODE_WIDTH-1:0] OP_R     = OPCODE_WIDTH'(7'b0110011);
  localparam logic [OPCODE_WIDTH-1:0] OP_I     = OPCODE_WIDTH'(7'b0010011);
  localparam logic [FUNCT7_WIDTH-1:0] F7_ALT   = FUNCT7_WIDTH'(7'b0100000);
  localparam logic [6:0]              IMM_ALT  = 7'b0100000;
  localparam logic [FUNCT3_WIDTH-1:0] F3_ADD   = FUNCT3_WIDTH'(0);
  localparam logic [FUNCT3_WIDTH-1:0] F3_SLL   = FUNCT3_WIDTH'(1);
  localparam logic [FUNCT3_WIDTH-1:0] F3_SLT   = FUNCT3_WIDTH'(2);
  localparam logic [FUNCT3_WIDTH-1:0] F3_SLTU  = FUNCT3_WIDTH'(3);
  localparam logic [FUNCT3_WIDTH-1:0] F3_XOR   = FUNCT3_WIDTH'(4);
  localparam logic [FUNCT3_WIDTH-1:0] F3_SR    = FUNCT3_WIDTH'(5);
  localparam logic [FUNCT3_WIDTH-1:0] F3_OR    = FUNCT3_WIDTH'(6);
  localparam logic [FUNCT3_WIDTH-1:0] F3_AND   = FUNCT3_WIDTH'(7);

  logic [DATA_WIDTH-1:0]   op1_a [NUM_REQ];
  logic [DATA_WIDTH-1:0]   op2_a [NUM_REQ];
  logic [OPCODE_WIDTH-1:0] opc_a [NUM_REQ];
  logic [FUNCT3_WIDTH-1:0] f3_a  [NUM_REQ];
  logic [FUNCT7_WIDTH-1:0] f7_a  [NUM_REQ];
  logic [TAG_WIDTH-1:0]    tag_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op1_a[g] = req_operand1[g*DATA_WIDTH +: DATA_WIDTH];
    assign op2_a[g] = req_operand2[g*DATA_WIDTH +: DATA_WIDTH];
    assign opc_a[g] = req_opcode[g*OPCODE_WIDTH +: OPCODE_WIDTH];
    assign f3_a[g]  = req_funct3[g*FUNCT3_WIDTH +: FUNCT3_WIDTH];
    assign f7_a[g]  = req_funct7[g*FUNCT7_WIDTH +: FUNCT7_WIDTH];
    assign tag_a[g] = req_tag[g*TAG_WIDTH +: TAG_WIDTH];
  end

  logic                    s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0]   s1_op1_q, s1_op2_q;
  logic [OPCODE_WIDTH-1:0] s1_opc_q;
  logic [FUNCT3_WIDTH-1:0] s1_f3_q;
  logic [FUNCT7_WIDTH-1:0] s1_f7_q;
  logic [TAG_WIDTH-1:0]    s1_tag_q;
  logic [SRC_W-1:0]        s1_src_q;

  logic                    s2_valid_q, s2_valid_d;
  logic [DATA_WIDTH-1:0]   s2_result_q;
  logic                    s2_zero_q;
  logic [TAG_WIDTH-1:0]    s2_tag_q;
  logic [SRC_W-1:0]        s2_src_q;

  logic [SRC_W-1:0]        rr_ptr_q, rr_ptr_d;

  logic                    s2_adv, s1_adv, s1_to_s2;
  logic                    gnt_found, hs;
  logic [SRC_W-1:0]        gnt_idx, rr_idx;
  logic [DATA_WIDTH-1:0]   alu_res;
  logic [4:0]              shamt;
  logic                    is_r, is_i, alt_r, alt_i;

  assign s2_adv   = ~s2_valid_q | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign s1_to_s2 = s1_valid_q & s2_adv & ~flush;
  assign hs       = gnt_found & s1_adv & ~flush;

  // First valid requester at or after rr_ptr, wrapping past NUM_REQ-1.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    rr_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_idx = SRC_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!gnt_found && req_valid[rr_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = rr_idx;
      end
    end
  end

  // rst_n gates ready so nothing looks accepted while the core is held in reset.
  always_comb begin
    req_ready = '0;
    if (hs && rst_n) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (hs) rr_ptr_d = (gnt_idx == LAST_SRC) ? '0 : gnt_idx + 1'b1;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (flush)       s1_valid_d = 1'b0;
    else if (hs)     s1_valid_d = 1'b1;
    else if (s1_adv) s1_valid_d = 1'b0;
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    if (flush)          s2_valid_d = 1'b0;
    else if (s1_to_s2)  s2_valid_d = 1'b1;
    else if (out_ready) s2_valid_d = 1'b0;
  end

  // RV32I integer ALU; unknown opcodes fall back to ADD.
  always_comb begin
    shamt   = s1_op2_q[4:0];
    is_r    = (s1_opc_q == OP_R);
    is_i    = (s1_opc_q == OP_I);
    alt_r   = (s1_f7_q == F7_ALT);
    alt_i   = (s1_op2_q[11:5] == IMM_ALT);
    alu_res = s1_op1_q + s1_op2_q;
    if (is_r || is_i) begin
      case (s1_f3_q)
        F3_ADD:  alu_res = (is_r && alt_r) ? s1_op1_q - s1_op2_q : s1_op1_q + s1_op2_q;
        F3_SLL:  alu_res = s1_op1_q << shamt;
        F3_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(s1_op1_q) < $signed(s1_op2_q)};
        F3_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, s1_op1_q < s1_op2_q};
        F3_XOR:  alu_res = s1_op1_q ^ s1_op2_q;
        F3_SR:   alu_res = (is_r ? alt_r : alt_i) ? DATA_WIDTH'($signed(s1_op1_q) >>> shamt)
                                                  : s1_op1_q >> shamt;
        F3_OR:   alu_res = s1_op1_q | s1_op2_q;
        F3_AND:  alu_res = s1_op1_q & s1_op2_q;
        default: alu_res = s1_op1_q + s1_op2_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_op1_q    <= '0;
      s1_op2_q    <= '0;
      s1_opc_q    <= '0;
      s1_f3_q     <= '0;
      s1_f7_q     <= '0;
      s1_tag_q    <= '0;
      s1_src_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_zero_q   <= 1'b1;
      s2_tag_q    <= '0;
      s2_src_q    <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (hs) begin
        s1_op1_q <= op1_a[gnt_idx];
        s1_op2_q <= op2_a[gnt_idx];
        s1_opc_q <= opc_a[gnt_idx];
        s1_f3_q  <= f3_a[gnt_idx];
        s1_f7_q  <= f7_a[gnt_idx];
        s1_tag_q <= tag_a[gnt_idx];
        s1_src_q <= gnt_idx;
      end
      if (s1_to_s2) begin
        s2_result_q <= alu_res;
        s2_zero_q   <= (alu_res == '0);
        s2_tag_q    <= s1_tag_q;
        s2_src_q    <= s1_src_q;
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_result_q;
  assign out_zero   = s2_zero_q;
  assign out_tag    = s2_tag_q;
  assign out_src    = s2_src_q;
  assign inflight   = {1'b0, s1_valid_q} + {1'b0, s2_valid_q};

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Scoreboard bench for alu_issue_arbiter: directed ops per requester, expected
// results queued at issue time and popped by a monitor on each output transfer.
module tb_alu_issue_arbiter;
  localparam int N = 4, DW = 32, TW = 6, OW = 7, F3W = 3, F7W = 7, SW = 2;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, F7A = 7'b0100000;

  logic clk, rst_n, flush, out_ready, out_valid, out_zero;
  logic [N-1:0] req_valid, req_ready, last_ready;
  logic [N*DW-1:0] req_operand1, req_operand2;
  logic [N*OW-1:0] req_opcode;
  logic [N*F3W-1:0] req_funct3;
  logic [N*F7W-1:0] req_funct7;
  logic [N*TW-1:0] req_tag;
  logic [DW-1:0] out_result;
  logic [TW-1:0] out_tag;
  logic [SW-1:0] out_src;
  logic [1:0] inflight;

  typedef struct {
    logic [31:0] a, b;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [5:0] tag;
  } op_t;
  typedef struct {
    logic [31:0] res;
    logic zero;
    logic [5:0] tag;
    logic [1:0] src;
  } exp_t;

  op_t  rq[N][$];
  exp_t exp_q[$];
  int checks = 0, errors = 0, ncyc;

  alu_issue_arbiter dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_operand1(req_operand1), .req_operand2(req_operand2),
    .req_opcode(req_opcode), .req_funct3(req_funct3), .req_funct7(req_funct7),
    .req_tag(req_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_tag(out_tag),
    .out_src(out_src), .inflight(inflight)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [5:0] tag, input logic [31:0] res);
    op_t o;
    exp_t e;
    o.a = a; o.b = b; o.opc = opc; o.f3 = f3; o.f7 = f7; o.tag = tag;
    rq[i].push_back(o);
    e.res = res; e.zero = (res == 32'd0); e.tag = tag; e.src = 2'(i);
    exp_q.push_back(e);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_operand1[i*DW +: DW] = rq[i][0].a;
        req_operand2[i*DW +: DW] = rq[i][0].b;
        req_opcode[i*OW +: OW]   = rq[i][0].opc;
        req_funct3[i*F3W +: F3W] = rq[i][0].f3;
        req_funct7[i*F7W +: F7W] = rq[i][0].f7;
        req_tag[i*TW +: TW]      = rq[i][0].tag;
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
  task automatic step();
    logic [N-1:0] hs;
    drive();
    #3;
    last_ready = req_ready;
    hs = req_valid & req_ready;
    checks++;
    if (!$onehot0(req_ready)) begin
      errors++;
      $display("FAIL ready_onehot: got %b expected one-hot or zero", req_ready);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (hs[i]) void'(rq[i].pop_front());
  endtask

  function automatic bit all_idle();
    for (int i = 0; i < N; i++)
      if (rq[i].size() > 0) return 1'b0;
    return exp_q.size() == 0;
  endfunction

  task automatic drain(input string name, output int n);
    n = 0;
    while (!all_idle() && n < 300) begin
      step();
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s_drain: got %0d cycles expected completion under 300", name, n);
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_out_valid"}, out_valid, 0);
    chk({name, "_out_result"}, out_result, 0);
    chk({name, "_out_zero"}, out_zero, 1);
    chk({name, "_out_tag"}, out_tag, 0);
    chk({name, "_out_src"}, out_src, 0);
    chk({name, "_inflight"}, inflight, 0);
    chk({name, "_req_ready"}, req_ready, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got tag=%0d result=%h expected no output", out_tag, out_result);
      end else begin
        e = exp_q.pop_front();
        if (out_result !== e.res || out_zero !== e.zero || out_tag !== e.tag || out_src !== e.src) begin
          errors++;
          $display("FAIL result: got res=%h zero=%b tag=%0d src=%0d expected res=%h zero=%b tag=%0d src=%0d",
                   out_result, out_zero, out_tag, out_src, e.res, e.zero, e.tag, e.src);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    req_valid = '0; req_operand1 = '0; req_operand2 = '0; req_opcode = '0;
    req_funct3 = '0; req_funct7 = '0; req_tag = '0; last_ready = '0;
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single ADD from req0, two-stage latency
    issue(0, 32'd5, 32'd7, OP_R, 3'b000, 7'd0, 6'd3, 32'd12);
    step();
    chk("t1_inflight_after_accept", inflight, 1);
    chk("t1_out_valid_after_accept", out_valid, 0);
    step();
    chk("t1_out_valid_next", out_valid, 1);
    chk("t1_inflight_s2", inflight, 1);
    drain("t1", ncyc);

    // SLTU from req3 alone; moves rr_ptr back to 0
    issue(3, 32'd1, 32'hFFFF_FFFF, OP_R, 3'b011, 7'd0, 6'd7, 32'd1);
    drain("sltu", ncyc);

    // all four valid, two ops each: grants 0,1,2,3,0,1,2,3 at one per cycle
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++)
        issue(i, 32'(100*i + k), 32'd1, OP_R, 3'b000, 7'd0, 6'(16 + 4*k + i), 32'(100*i + k + 1));
    drain("t2", ncyc);
    chk("t2_cycles", ncyc, 10);

    // req2 alone (rr->3), then req1+req3 -> 3 first, then 1 (rr->2)
    issue(2, 32'd50, 32'd1, OP_R, 3'b000, 7'd0, 6'd40, 32'd51);
    drain("t3a", ncyc);
    issue(3, 32'd60, 32'd1, OP_R, 3'b000, 7'd0, 6'd41, 32'd61);
    issue(1, 32'd70, 32'd1, OP_R, 3'b000, 7'd0, 6'd42, 32'd71);
    drain("t3b", ncyc);
    issue(2, 32'd80, 32'd2, OP_R, 3'b000, 7'd0, 6'd43, 32'd82);
    issue(3, 32'd90, 32'd2, OP_R, 3'b000, 7'd0, 6'd44, 32'd92);
    issue(0, 32'd95, 32'd2, OP_R, 3'b000, 7'd0, 6'd45, 32'd97);
    drain("t3c", ncyc);

    // ALU decode vectors
    issue(0, 32'd4, 32'd4, OP_R, 3'b000, F7A, 6'd1, 32'd0);
    issue(0, 32'h8000_0000, 32'h0000_0404, OP_I, 3'b101, 7'd0, 6'd2, 32'hF800_0000);
    issue(0, 32'h8000_0000, 32'h0000_0004, OP_I, 3'b101, 7'd0, 6'd3, 32'h0800_0000);
    issue(0, 32'hFFFF_FFFF, 32'd1, OP_R, 3'b010, 7'd0, 6'd4, 32'd1);
    issue(0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, OP_R, 3'b100, 7'd0, 6'd5, 32'hFF00_FF00);
    issue(0, 32'd1, 32'h0000_0021, OP_R, 3'b001, 7'd0, 6'd6, 32'd2);
    issue(0, 32'h1234_0000, 32'h0000_5678, OP_R, 3'b110, 7'd0, 6'd7, 32'h1234_5678);
    issue(0, 32'hFFFF_0000, 32'h1234_5678, OP_R, 3'b111, 7'd0, 6'd8, 32'h1234_0000);
    issue(0, 32'hF000_0000, 32'd8, OP_R, 3'b101, F7A, 6'd9, 32'hFFF0_0000);
    issue(0, 32'hF000_0000, 32'd8, OP_R, 3'b101, 7'd0, 6'd10, 32'h00F0_0000);
    issue(0, 32'd10, 32'hFFFF_FFFF, OP_I, 3'b000, F7A, 6'd11, 32'd9);
    issue(0, 32'd3, 32'd4, 7'b0110111, 3'b100, F7A, 6'd12, 32'd7);
    issue(0, 32'd5, 32'd3, OP_I, 3'b011, 7'd0, 6'd13, 32'd0);
    drain("alu", ncyc);

    // backpressure: stall three cycles with the pipe full
    for (int k = 0; k < 8; k++)
      issue(0, 32'(1000 + k), 32'(k), OP_R, 3'b000, 7'd0, 6'(k), 32'(1000 + 2*k));
    repeat (3) step();
    out_ready = 1'b0;
    repeat (3) begin
      step();
      chk("bp_inflight", inflight, 2);
      chk("bp_req_ready", last_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_result", out_result, exp_q[0].res);
      chk("bp_out_tag", out_tag, exp_q[0].tag);
    end
    out_ready = 1'b1;
    drain("bp", ncyc);

    // flush with two ops in flight
    for (int k = 0; k < 6; k++)
      issue(0, 32'(k), 32'(k), OP_R, 3'b000, 7'd0, 6'(20 + k), 32'(2*k));
    repeat (3) step();
    chk("fl_inflight_before", inflight, 2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_req_ready", last_ready, 0);
    chk("fl_out_valid", out_valid, 0);
    chk("fl_inflight", inflight, 0);
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    drain("fl", ncyc);

    // asynchronous reset mid-stream, then rr_ptr must restart at 0
    for (int k = 0; k < 6; k++)
      issue(1, 32'(k), 32'd1, OP_R, 3'b000, 7'd0, 6'(30 + k), 32'(k + 1));
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    for (int i = 0; i < N; i++) rq[i].delete();
    exp_q.delete();
    drive();
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(1, 32'd200, 32'd1, OP_R, 3'b000, 7'd0, 6'd51, 32'd201);
    issue(3, 32'd300, 32'd1, OP_R, 3'b000, 7'd0, 6'd50, 32'd301);
    drain("post_rst", ncyc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
